// File: rtl/simple_bus_master_ctrl.sv
// simple_bus_master_ctrl: buffers core read/write commands in a FIFO and runs them one at a time on simple_bus
// Each command gets exactly one response, returned in command order.
module simple_bus_master_ctrl #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic [AW-1:0] bus_addr,
    output logic [1:0]    bus_mode,
    output logic          bus_start,
    input  logic          bus_rdy,
    output logic [DW-1:0] bus_data_out,
    output logic          bus_data_oe,
    input  logic [DW-1:0] bus_data_in,
    output logic          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_START, S_WAIT, S_RESP} state_t;

    state_t              r_state, w_next;
    logic [DW+AW+1:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_full;
    logic [AW-1:0]       r_addr;
    logic [1:0]          r_mode;
    logic [DW-1:0]       r_wdata, r_rdata;
    logic                r_err;
    logic [TW-1:0]       r_timer;
    logic                w_push, w_pop, w_timeout, w_timed;
    logic [CW-1:0]       w_count_next;
    logic [1:0]          w_head_mode;
    logic [AW-1:0]       w_head_addr;
    logic [DW-1:0]       w_head_wdata;

    assign w_push       = cmd_valid && !r_full;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_timeout    = r_timer == TW'(TIMEOUT - 1);
    assign w_timed      = (r_state == S_REQ) || (r_state == S_WAIT);
    assign {w_head_mode, w_head_addr, w_head_wdata} = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {cmd_mode, cmd_addr, cmd_wdata};
    end

    // Full flag is registered so cmd_ready never depends on a same-cycle pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= w_count_next;
            r_full   <= w_count_next == CW'(FIFO_DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_next = w_head_mode[1] ? S_RESP : S_REQ;
            S_REQ:   if (bus_gnt) w_next = S_START; else if (w_timeout) w_next = S_RESP;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (bus_rdy || w_timeout) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_mode  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            if (w_next != r_state) r_timer <= '0;
            else if (w_timed && r_timer != TW'(TIMEOUT)) r_timer <= r_timer + TW'(1);
            if (w_pop) begin
                r_addr  <= w_head_addr;
                r_mode  <= w_head_mode;
                r_wdata <= w_head_wdata;
                r_rdata <= '0;
                r_err   <= w_head_mode[1];
            end
            if (r_state == S_REQ && !bus_gnt && w_timeout) r_err <= 1'b1;
            if (r_state == S_WAIT && bus_rdy) r_rdata <= (r_mode == 2'b00) ? bus_data_in : '0;
            else if (r_state == S_WAIT && w_timeout) r_err <= 1'b1;
        end
    end

    always_comb begin
        bus_req      = (r_state == S_REQ) || (r_state == S_START) || (r_state == S_WAIT);
        bus_addr     = bus_req ? r_addr : '0;
        bus_mode     = bus_req ? r_mode : '0;
        bus_start    = r_state == S_START;
        bus_data_oe  = ((r_state == S_START) || (r_state == S_WAIT)) && (r_mode == 2'b01);
        bus_data_out = bus_data_oe ? r_wdata : '0;
        rsp_valid    = r_state == S_RESP;
        rsp_rdata    = rsp_valid ? r_rdata : '0;
        rsp_err      = rsp_valid && r_err;
        cmd_ready    = !r_full;
        busy         = (r_count != '0) || (r_state != S_IDLE);
    end
endmodule
